// File: rtl/seq_frac_divider.sv
// Multi-cycle restoring divider producing floor((num << FRAC_W) / den),
// one quotient bit per clock, with saturation and divide-by-zero flagging.
module seq_frac_divider #(
  parameter int NUM_W  = 18,
  parameter int DEN_W  = 18,
  parameter int FRAC_W = 8,
  parameter int Q_W    = 8,
  parameter bit AUTO   = 1'b0
) (
  input  logic             clk,
  input  logic             nrst,
  input  logic             start,
  input  logic [NUM_W-1:0] num,
  input  logic [DEN_W-1:0] den,
  output logic             busy,
  output logic             valid,
  output logic [Q_W-1:0]   q_out,
  output logic             sat,
  output logic             dbz
);

  localparam int N_W   = NUM_W + FRAC_W;
  localparam int CNT_W = (N_W > 1) ? $clog2(N_W) : 1;
  localparam logic [CNT_W-1:0] LAST = CNT_W'(N_W - 1);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t           state_q;
  logic [N_W-1:0]   d_q;
  logic [DEN_W:0]   r_q;
  logic [Q_W-1:0]   qs_q;
  logic             ovf_q;
  logic [DEN_W-1:0] den_q;
  logic             dbz_l_q;
  logic [CNT_W-1:0] cnt_q;
  logic [Q_W-1:0]   q_out_q;
  logic             valid_q;
  logic             sat_q;
  logic             dbz_q;

  logic             go;
  logic [DEN_W:0]   r_shift;
  logic [DEN_W:0]   r_d;
  logic             q_bit_d;

  assign go = AUTO ? 1'b1 : start;

  // A zero divisor forces the compare true so the run length stays constant.
  always_comb begin
    r_shift = {r_q[DEN_W-1:0], d_q[N_W-1]};
    q_bit_d = dbz_l_q || (r_shift >= {1'b0, den_q});
    r_d     = q_bit_d ? (r_shift - {1'b0, den_q}) : r_shift;
  end

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      state_q <= IDLE;
      d_q     <= '0;
      r_q     <= '0;
      qs_q    <= '0;
      ovf_q   <= 1'b0;
      den_q   <= '0;
      dbz_l_q <= 1'b0;
      cnt_q   <= '0;
      q_out_q <= '0;
      valid_q <= 1'b0;
      sat_q   <= 1'b0;
      dbz_q   <= 1'b0;
    end else begin
      valid_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (go) begin
            d_q     <= {num, {FRAC_W{1'b0}}};
            r_q     <= '0;
            qs_q    <= '0;
            ovf_q   <= 1'b0;
            den_q   <= den;
            dbz_l_q <= (den == '0);
            cnt_q   <= '0;
            state_q <= RUN;
          end
        end
        RUN: begin
          d_q     <= {d_q[N_W-2:0], 1'b0};
          r_q     <= r_d;
          qs_q    <= {qs_q[Q_W-2:0], q_bit_d};
          // Any 1 shifted out of the quotient register means the result overflowed.
          ovf_q   <= ovf_q | qs_q[Q_W-1];
          cnt_q   <= cnt_q + CNT_W'(1);
          if (cnt_q == LAST) state_q <= DONE;
        end
        DONE: begin
          q_out_q <= (ovf_q | dbz_l_q) ? '1 : qs_q;
          sat_q   <= ovf_q & ~dbz_l_q;
          dbz_q   <= dbz_l_q;
          valid_q <= 1'b1;
          state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign busy  = (state_q != IDLE);
  assign valid = valid_q;
  assign q_out = q_out_q;
  assign sat   = sat_q;
  assign dbz   = dbz_q;

endmodule

// File: tb/tb_seq_frac_divider.sv
// Scoreboard bench for seq_frac_divider: one handshake-driven instance and
// one free-running instance, each with its own expected-result queue.
module tb_seq_frac_divider;

  typedef struct {
    int q;
    int sat;
    int dbz;
    int acc;
  } exp_t;

  logic        clk;
  logic        nrst0, nrst1;
  logic        start0, start1;
  logic [17:0] num0, den0, num1, den1;
  logic        busy0, valid0, sat0, dbz0;
  logic        busy1, valid1, sat1, dbz1;
  logic [7:0]  q_out0, q_out1;

  int   cyc = 0;
  int   checks = 0;
  int   failures = 0;
  int   vcnt0 = 0;
  exp_t sb0[$];
  exp_t sb1[$];

  seq_frac_divider #(.NUM_W(18), .DEN_W(18), .FRAC_W(8), .Q_W(8), .AUTO(1'b0)) u0 (
    .clk(clk), .nrst(nrst0), .start(start0), .num(num0), .den(den0),
    .busy(busy0), .valid(valid0), .q_out(q_out0), .sat(sat0), .dbz(dbz0)
  );

  seq_frac_divider #(.NUM_W(18), .DEN_W(18), .FRAC_W(8), .Q_W(8), .AUTO(1'b1)) u1 (
    .clk(clk), .nrst(nrst1), .start(start1), .num(num1), .den(den1),
    .busy(busy1), .valid(valid1), .q_out(q_out1), .sat(sat1), .dbz(dbz1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Monitor for the handshake instance
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (valid0) begin
        vcnt0++;
        if (sb0.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL unexpected_valid0: q_out=%0d with empty queue (cycle %0d)", q_out0, cyc);
        end else begin
          e = sb0.pop_front();
          chk("q_out0", int'(q_out0), e.q);
          chk("sat0", int'(sat0), e.sat);
          chk("dbz0", int'(dbz0), e.dbz);
          chk("latency0", cyc - e.acc, 27);
        end
      end
    end
  end

  // Monitor for the free-running instance
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (valid1) begin
        if (sb1.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL unexpected_valid1: q_out=%0d with empty queue (cycle %0d)", q_out1, cyc);
        end else begin
          e = sb1.pop_front();
          chk("q_out1", int'(q_out1), e.q);
          chk("sat1", int'(sat1), e.sat);
          chk("dbz1", int'(dbz1), e.dbz);
          chk("accept_time1", cyc - e.acc, 27);
        end
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  task automatic push0(input int q, input int s, input int z, input int acc);
    exp_t e;
    e.q = q; e.sat = s; e.dbz = z; e.acc = acc;
    sb0.push_back(e);
  endtask

  task automatic push1(input int q, input int acc);
    exp_t e;
    e.q = q; e.sat = 0; e.dbz = 0; e.acc = acc;
    sb1.push_back(e);
  endtask

  // Leaves the caller at the falling edge right after the accepting edge.
  task automatic issue0(input int n, input int d, input int q, input int s, input int z);
    @(negedge clk);
    num0   = 18'(n);
    den0   = 18'(d);
    start0 = 1'b1;
    push0(q, s, z, cyc + 1);
    @(negedge clk);
    start0 = 1'b0;
  endtask

  task automatic wait_idle0(input string name, input int exp_cnt);
    int bcnt;
    bcnt = 0;
    while (busy0 && bcnt < 200) begin
      bcnt++;
      @(negedge clk);
    end
    chk(name, bcnt, exp_cnt);
  endtask

  initial begin
    int acc;
    int vsnap;
    nrst0 = 1'b0; nrst1 = 1'b0;
    start0 = 1'b0; start1 = 1'b0;
    num0 = '0; den0 = '0; num1 = '0; den1 = '0;
    repeat (3) @(negedge clk);
    chk("rst_q_out", int'(q_out0), 0);
    chk("rst_valid", int'(valid0), 0);
    chk("rst_busy", int'(busy0), 0);
    chk("rst_sat", int'(sat0), 0);
    chk("rst_dbz", int'(dbz0), 0);
    nrst0 = 1'b1;
    repeat (2) @(negedge clk);

    // Basic ratios, saturation, zero numerator
    issue0(1000, 2000, 128, 0, 0); wait_idle0("busy_len_1000_2000", 27);
    issue0(3, 7, 109, 0, 0);       wait_idle0("busy_len_3_7", 27);
    issue0(2000, 2000, 255, 1, 0); wait_idle0("busy_len_sat", 27);
    issue0(0, 5, 0, 0, 0);         wait_idle0("busy_len_zero_num", 27);

    // Divide by zero, then flags clear on the next result
    issue0(42, 0, 255, 0, 1);      wait_idle0("busy_len_dbz", 27);
    issue0(0, 1, 0, 0, 0);         wait_idle0("busy_len_after_dbz", 27);

    // start mid-run is ignored; input changes after accept do not matter
    issue0(1000, 2000, 128, 0, 0);
    repeat (9) @(negedge clk);
    num0 = 18'd5; den0 = 18'd1; start0 = 1'b1;
    @(negedge clk);
    start0 = 1'b0;
    wait_idle0("busy_len_ignored_start", 17);

    // start held high: accepts coincide with the valid cycle
    @(negedge clk);
    num0 = 18'd3; den0 = 18'd7; start0 = 1'b1;
    acc = cyc + 1;
    push0(109, 0, 0, acc);
    push0(109, 0, 0, acc + 28);
    push0(109, 0, 0, acc + 56);
    while (cyc < acc + 56) @(negedge clk);
    start0 = 1'b0;
    wait_idle0("busy_len_back_to_back", 27);

    // Reset in the middle of a division
    @(negedge clk);
    num0 = 18'd1000; den0 = 18'd2000; start0 = 1'b1;
    @(negedge clk);
    start0 = 1'b0;
    repeat (10) @(negedge clk);
    nrst0 = 1'b0;
    #1;
    chk("midrst_q_out", int'(q_out0), 0);
    chk("midrst_valid", int'(valid0), 0);
    chk("midrst_busy", int'(busy0), 0);
    @(negedge clk);
    nrst0 = 1'b1;
    vsnap = vcnt0;
    repeat (40) @(negedge clk);
    chk("no_valid_after_rst", vcnt0, vsnap);
    chk("idle_after_rst", int'(busy0), 0);
    chk("sb0_drained", sb0.size(), 0);

    // Free-running instance
    num1 = 18'd500; den1 = 18'd1000;
    @(negedge clk);
    nrst1 = 1'b1;
    acc = cyc + 1;
    push1(128, acc);
    push1(128, acc + 28);
    push1(64, acc + 56);
    push1(64, acc + 84);
    while (cyc < acc + 33) @(negedge clk);
    num1 = 18'd250;
    while (cyc < acc + 111) @(negedge clk);
    nrst1 = 1'b0;
    #1;
    chk("auto_rst_busy", int'(busy1), 0);
    chk("sb1_drained", sb1.size(), 0);

    repeat (2) @(negedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/seq_frac_divider.md
Name: seq_frac_divider

Overview:
Parametrised multi-cycle restoring divider computing a fixed-point ratio q = floor((num << FRAC_W) / den), one quotient bit per clock. It is the next-generation oscillator-shaping divider: the operand, fraction and result widths are configurable. It adds a start/busy/valid handshake, an optional free-running mode, saturation on overflow, and divide-by-zero flagging. It sits between the oscillator/accumulator path and the waveform output stage.

Parameters:
NUM_W, 18, dividend (num) width
DEN_W, 18, divisor (den) width
FRAC_W, 8, fractional bits appended to num before dividing
Q_W, 8, result width; quotient saturates to 2^Q_W-1
AUTO, 0, 1 = free-running: internal start whenever IDLE, external start ignored

Ports:
clk  in  1  system clock, rising edge
nrst  in  1  asynchronous active-low reset
start  in  1  request; accepted only in IDLE
num  in  NUM_W  dividend, sampled on accept
den  in  DEN_W  divisor, sampled on accept
busy  out  1  high while state != IDLE
valid  out  1  one-cycle pulse when q_out/sat/dbz update
q_out  out  Q_W  result, held until next valid
sat  out  1  result saturated (true quotient >= 2^Q_W), held with q_out
dbz  out  1  den was 0 for this result, held with q_out

Behaviour:
- Reset (async, nrst low): state=IDLE; q_out=0, valid=0, busy=0, sat=0, dbz=0; all internal registers cleared. Reset mid-operation abandons the division with no valid pulse; q_out returns to 0.
- N_W = NUM_W+FRAC_W. Internal registers: dividend shift D[N_W], partial remainder R[DEN_W+1], quotient shift Q[Q_W], sticky ovf, latched den, dbz_l, count[ceil(log2(N_W))].
- FSM IDLE -> RUN -> DONE -> IDLE.
- IDLE: go = start (AUTO=0) or 1 (AUTO=1). On go at edge k: D={num,FRAC_W zeros}, R=0, Q=0, ovf=0, den latched, dbz_l=(den==0), count=0, state -> RUN.
- RUN, one step per edge: R'={R[DEN_W-1:0], D msb}; D<<=1; if R' >= den then R=R'-den, bit=1, else R=R', bit=0. Q={Q[Q_W-2:0],bit}; ovf |= old Q msb. Steps run on edges k+1..k+N_W; when count==N_W-1 -> DONE.
- DONE at edge k+N_W+1: q_out = (ovf|dbz_l) ? all ones : Q; sat=ovf&~dbz_l; dbz=dbz_l; valid=1 for exactly one cycle; state -> IDLE.
- Latency: constant N_W+1 edges from accept to valid (27 at defaults), including den=0. den=0 runs the full length with the compare forced true; the result is forced to all ones.
- start while busy is ignored and not queued. start in the cycle valid is high is accepted, since state is IDLE. Back-to-back period is N_W+2 cycles.
- num/den changes after acceptance do not affect the current division.
- busy is decoded from state and is combinational-equivalent to state != IDLE.
- All arithmetic is unsigned. The comparison is DEN_W+1 bits wide, so R' never wraps.

Test Plan:
1. Defaults, AUTO=0: num=1000, den=2000, start one cycle -> busy for 27 cycles; valid pulses exactly 27 edges after accept; q_out=128, sat=0, dbz=0.
2. num=3, den=7 -> q_out=109 (768/7). Then num=2000, den=2000 -> q_out=255, sat=1. Then num=0, den=5 -> q_out=0, sat=0.
3. den=0, num=42 -> valid after same 27-edge latency; q_out=255, dbz=1, sat=0. Next division with den=1, num=0 clears dbz and sat.
4. Handshake: pulse start mid-RUN with num=5, den=1 -> ignored, first result unaffected. Hold start high -> new accept coincides with the valid cycle; results arrive every 28 cycles.
5. Assert nrst low at step 10 of a division -> q_out=0, valid=0, busy=0 immediately. After release, no valid pulse until a new start.
6. AUTO=1, num=500, den=1000 constant, start tied 0 -> valid pulses every 28 cycles, each with q_out=128. Changing num to 250 affects only the next conversion, giving q_out=64.
